// File: rtl/lfsr_seg_sampler.sv
// Samples a 4-bit LFSR word at a selectable rate, keeps a short history, and drives a
// registered hex 7-segment decode with repeat/stuck flags and a hold (freeze) mode.
module lfsr_seg_sampler #(
    parameter int HIST_DEPTH = 4,
    parameter int RATE_SHIFT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] lfsr_in,
    input  logic [1:0] rate_sel,
    input  logic       hold,
    input  logic [1:0] show_sel,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic       sample_valid,
    output logic       repeat_flag,
    output logic       stuck_flag,
    output logic [1:0] dbg_state
);

    localparam int CW = RATE_SHIFT * 3;
    localparam int FW = $clog2(HIST_DEPTH + 1);

    // Debug encoding is part of the interface: IDLE=0, RUN=1, HOLD=2.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_period_m1;
    logic            w_tick;
    logic [3:0]      r_hist [HIST_DEPTH];
    logic [FW-1:0]   r_fill;
    logic [3:0]      w_sel_nib;
    logic            w_sel_blank;
    logic [6:0]      r_seg;
    logic            r_dp;
    logic            r_valid;
    logic            r_repeat;
    logic            r_stuck;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // ena/hold act through the state register: the cycle they change still behaves per
    // the current state, so a tick in the last RUN cycle is still captured.
    always_comb begin
        w_state_nxt = r_state;
        if (!ena) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_RUN;
                S_RUN:   w_state_nxt = hold ? S_HOLD : S_RUN;
                S_HOLD:  w_state_nxt = hold ? S_HOLD : S_RUN;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_period_m1 = {CW{1'b1}} >> (CW - RATE_SHIFT * int'(rate_sel));
        w_tick      = (r_state == S_RUN) && (r_cnt >= w_period_m1);
    end

    always_comb begin
        w_sel_nib = 4'h0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (int'(show_sel) == i) w_sel_nib = r_hist[i];
        end
        w_sel_blank = (int'(show_sel) >= int'(r_fill)) || (int'(show_sel) >= HIST_DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!ena || r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= 4'h0;
            r_fill   <= '0;
            r_valid  <= 1'b0;
            r_repeat <= 1'b0;
            r_stuck  <= 1'b0;
        end else begin
            r_valid <= w_tick;
            if (w_tick) begin
                r_hist[0] <= lfsr_in;
                for (int i = 1; i < HIST_DEPTH; i++) r_hist[i] <= r_hist[i-1];
                if (int'(r_fill) < HIST_DEPTH) r_fill <= r_fill + 1'b1;
                r_repeat <= (lfsr_in == r_hist[0]) && (r_fill != '0);
                if (lfsr_in == 4'h0) r_stuck <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 7'h00;
            r_dp  <= 1'b0;
        end else begin
            r_seg <= w_sel_blank ? 7'h00 : hex_to_seg(w_sel_nib);
            r_dp  <= (r_state == S_HOLD);
        end
    end

    assign seg_out      = r_seg;
    assign dp_out       = r_dp;
    assign sample_valid = r_valid;
    assign repeat_flag  = r_repeat;
    assign stuck_flag   = r_stuck;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_lfsr_seg_sampler.sv
// Self-checking bench for lfsr_seg_sampler: directed steps plus random stimulus checked
// every cycle against a queue-based behavioural model.
module tb_lfsr_seg_sampler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] lfsr_in = 4'h0;
    logic [1:0] rate_sel = 2'd0;
    logic [1:0] show_sel = 2'd0;
    logic [6:0] seg_out;
    logic       dp_out;
    logic       sample_valid;
    logic       repeat_flag;
    logic       stuck_flag;
    logic [1:0] dbg_state;

    int total = 0;
    int bad = 0;

    // Model: state 0=IDLE 1=RUN 2=HOLD, history as a newest-first queue capped at 4.
    int         m_state;
    int         m_cnt;
    logic [3:0] m_hist[$];
    logic [6:0] m_seg;
    logic       m_dp;
    logic       m_valid;
    logic       m_rep;
    logic       m_stuck;
    logic [6:0] hex_tab [16];

    int cyc;
    int first_pulse;
    int second_pulse;
    logic [6:0] exp_show [4];

    always #5 clk = ~clk;

    lfsr_seg_sampler #(.HIST_DEPTH(4), .RATE_SHIFT(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .lfsr_in(lfsr_in), .rate_sel(rate_sel),
        .hold(hold), .show_sel(show_sel), .seg_out(seg_out), .dp_out(dp_out),
        .sample_valid(sample_valid), .repeat_flag(repeat_flag), .stuck_flag(stuck_flag),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_hist.delete();
        m_seg   = 7'h00;
        m_dp    = 1'b0;
        m_valid = 1'b0;
        m_rep   = 1'b0;
        m_stuck = 1'b0;
    endtask

    task automatic model_update();
        bit         tick;
        int         pm1;
        int         ns;
        int         nc;
        logic [6:0] nseg;
        pm1  = (1 << (4 * int'(rate_sel))) - 1;
        tick = (m_state == 1) && (m_cnt >= pm1);
        nseg = (int'(show_sel) < m_hist.size()) ? hex_tab[m_hist[show_sel]] : 7'h00;
        if (!ena) ns = 0;
        else if (m_state == 0) ns = 1;
        else ns = hold ? 2 : 1;
        if (!ena || m_state == 0) nc = 0;
        else if (m_state == 1) nc = tick ? 0 : m_cnt + 1;
        else nc = m_cnt;
        m_dp    = (m_state == 2);
        m_valid = tick;
        if (tick) begin
            m_rep = (m_hist.size() != 0) && (lfsr_in == m_hist[0]);
            if (lfsr_in == 4'h0) m_stuck = 1'b1;
            m_hist.push_front(lfsr_in);
            if (m_hist.size() > 4) void'(m_hist.pop_back());
        end
        m_state = ns;
        m_cnt   = nc;
        m_seg   = nseg;
    endtask

    task automatic check_all();
        check("seg", seg_out, m_seg);
        check("dp", dp_out, m_dp);
        check("valid", sample_valid, m_valid);
        check("repeat", repeat_flag, m_rep);
        check("stuck", stuck_flag, m_stuck);
        check("state", dbg_state, m_state[1:0]);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    // Reset asserted away from the clock edge: outputs must clear without waiting for clk.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_seg", seg_out, 7'h00);
        check("rst_dp", dp_out, 1'b0);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_repeat", repeat_flag, 1'b0);
        check("rst_stuck", stuck_flag, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b0;
        hold = 1'b0;
    endtask

    initial begin
        hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        step();

        // Five consecutive samples at rate 0, then freeze and walk the history.
        ena = 1'b1;
        step();
        for (int v = 1; v <= 5; v++) begin
            lfsr_in = 4'(v);
            if (v == 5) hold = 1'b1;
            step();
        end
        exp_show = '{7'h6D, 7'h66, 7'h4F, 7'h5B};
        for (int s = 0; s < 4; s++) begin
            show_sel = 2'(s);
            step();
            check("hist_show", seg_out, exp_show[s]);
        end
        check("dp_hold", dp_out, 1'b1);

        // Hold for 50 cycles: nothing captured while lfsr_in keeps changing.
        show_sel = 2'd0;
        for (int k = 0; k < 50; k++) begin
            lfsr_in = 4'($urandom_range(0, 15));
            step();
            check("hold_valid", sample_valid, 1'b0);
            check("hold_dp", dp_out, 1'b1);
        end
        check("hold_hist", seg_out, 7'h6D);
        hold = 1'b0;
        step();
        step();
        check("resume_valid", sample_valid, 1'b1);

        // Stuck-at-zero capture is sticky.
        lfsr_in = 4'h0;
        step();
        for (int k = 0; k < 8; k++) begin
            lfsr_in = 4'($urandom_range(1, 15));
            step();
        end
        check("stuck_sticky", stuck_flag, 1'b1);

        // Drop ena mid-count at rate 2: back to IDLE, no pulses, history kept.
        rate_sel = 2'd2;
        repeat (30) step();
        ena = 1'b0;
        for (int k = 0; k < 20; k++) begin
            lfsr_in = 4'($urandom_range(0, 15));
            step();
            check("idle_valid", sample_valid, 1'b0);
            check("idle_state", dbg_state, 2'd0);
        end

        // Fill boundary: a single capture of A shows only at index 0.
        do_reset();
        rate_sel = 2'd0;
        show_sel = 2'd0;
        step();
        check("post_rst_seg", seg_out, 7'h00);
        ena = 1'b1;
        step();
        ena = 1'b0;
        lfsr_in = 4'hA;
        step();
        exp_show = '{7'h77, 7'h00, 7'h00, 7'h00};
        for (int s = 0; s < 4; s++) begin
            show_sel = 2'(s);
            step();
            check("fill_show", seg_out, exp_show[s]);
        end

        // Rate 1 with a constant word: pulses 16 clocks apart, second one flags repeat.
        do_reset();
        rate_sel = 2'd1;
        show_sel = 2'd0;
        lfsr_in = 4'h9;
        ena = 1'b1;
        first_pulse = -1;
        second_pulse = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (sample_valid === 1'b1) begin
                if (first_pulse < 0) first_pulse = cyc;
                else if (second_pulse < 0) second_pulse = cyc;
            end
        end
        check("pulse_gap", 7'(second_pulse - first_pulse), 7'd16);
        check("repeat_9", repeat_flag, 1'b1);
        check("seg_9", seg_out, 7'h6F);

        // Random traffic, including rate changes mid-count and short holds.
        for (int k = 0; k < 600; k++) begin
            lfsr_in  = 4'($urandom_range(0, 15));
            show_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) rate_sel = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) hold = ~hold;
            ena = ($urandom_range(0, 24) != 0);
            if (k == 300) begin
                do_reset();
                step();
                check("mid_rst_seg", seg_out, 7'h00);
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
